// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Includes the Q-format round/saturate function used when MUL_Q15_OUT_EN is defined.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;
    localparam int Q_CALC_W  = 2 * MAX_WIDTH + 2;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // p must already be sign- or zero-extended to Q_CALC_W according to mode.
    function automatic logic [MAX_WIDTH-1:0] q_round_sat(
        input logic signed [Q_CALC_W-1:0] p,
        input int                         width,
        input logic                       is_signed
    );
        logic signed [Q_CALC_W-1:0] sum;
        logic signed [Q_CALC_W-1:0] q;
        logic signed [Q_CALC_W-1:0] hi;
        logic signed [Q_CALC_W-1:0] lo;
        sum = p + (Q_CALC_W'(1) <<< (width - 2));
        q   = sum >>> (width - 1);
        if (is_signed) begin
            hi = (Q_CALC_W'(1) <<< (width - 1)) - Q_CALC_W'(1);
            lo = -(Q_CALC_W'(1) <<< (width - 1));
        end else begin
            hi = (Q_CALC_W'(1) <<< width) - Q_CALC_W'(1);
            lo = '0;
        end
        if (q > hi) begin
            q = hi;
        end else if (q < lo) begin
            q = lo;
        end
        return q[MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mul_sat_round.sv
// Combinational round-half-up and saturation of a full product down to WIDTH bits.
// Only instantiated when MUL_Q15_OUT_EN is defined.
module mul_sat_round
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] i_p,
    input  logic               i_signed,
    output logic [WIDTH-1:0]   o_q
);

    logic signed [Q_CALC_W-1:0] w_p_ext;

    assign w_p_ext = i_signed ? {{(Q_CALC_W-2*WIDTH){i_p[2*WIDTH-1]}}, i_p}
                              : {{(Q_CALC_W-2*WIDTH){1'b0}}, i_p};

    assign o_q = WIDTH'(q_round_sat(w_p_ext, WIDTH, i_signed));

endmodule

// File: rtl/mul_seq_shiftadd.sv
// Iterative radix-2 shift-add multiplier, one multiplier bit per clock, signed/unsigned at runtime.
// Define MUL_Q15_OUT_EN to add the rounded, saturated out_q result port.
module mul_seq_shiftadd
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
`ifdef MUL_Q15_OUT_EN
    ,
    output logic [WIDTH-1:0]   out_q
`endif
);

    localparam int P_W = prod_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_signed;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last;
    logic [WIDTH:0]     w_pp;
    logic [WIDTH:0]     w_acc_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [P_W-1:0]     w_prod;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Extending acc by its sign bit makes the one-place right shift arithmetic in signed mode.
    assign w_pp      = r_b[0] ? {r_signed & r_a[WIDTH-1], r_a} : '0;
    assign w_acc_ext = {r_signed & r_acc[WIDTH-1], r_acc};
    assign w_sum     = (w_last && r_signed) ? (w_acc_ext - w_pp) : (w_acc_ext + w_pp);
    assign w_acc_nxt = w_sum[WIDTH:1];
    assign w_b_nxt   = {w_sum[0], r_b[WIDTH-1:1]};

    assign w_prod = {r_acc, r_b};
    assign out_p  = w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_signed <= in_signed;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MUL_Q15_OUT_EN
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_q;

    mul_sat_round #(
        .WIDTH (WIDTH)
    ) u_sat_round (
        .i_p      ({w_acc_nxt, w_b_nxt}),
        .i_signed (r_signed),
        .o_q      (w_q_nxt)
    );

    // Captured on the last iteration so out_q lines up with out_p when DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (r_state == RUN && w_last) begin
            r_q <= w_q_nxt;
        end
    end

    assign out_q = r_q;
`else
    // No Q-format output in this build; out_p is the only result.
`endif

endmodule

// File: tb/tb_mul_seq_shiftadd.sv
// Self-checking bench for mul_seq_shiftadd: directed corner cases plus a randomised
// sweep at WIDTH=16 and WIDTH=8 against an arithmetic reference model.
module tb_mul_seq_shiftadd;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, sg16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        iv8, ir8, sg8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
`ifdef MUL_Q15_OUT_EN
    logic [15:0] q16;
    logic [7:0]  q8;
`endif

    int checks = 0;
    int errors = 0;

    mul_seq_shiftadd #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_a      (a16),
        .in_b      (b16),
        .in_signed (sg16),
        .out_valid (ov16),
        .out_ready (or16),
        .out_p     (p16)
`ifdef MUL_Q15_OUT_EN
        ,
        .out_q     (q16)
`endif
    );

    mul_seq_shiftadd #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
        .in_signed (sg8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_p     (p8)
`ifdef MUL_Q15_OUT_EN
        ,
        .out_q     (q8)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_p(int w, logic [31:0] a, logic [31:0] b, logic s);
        longint mw, av, bv;
        mw = longint'(1) << w;
        av = longint'(a) & (mw - 1);
        bv = longint'(b) & (mw - 1);
        if (s && av >= mw / 2) av = av - mw;
        if (s && bv >= mw / 2) bv = bv - mw;
        return 64'(av * bv) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_q(int w, logic [63:0] p, logic s);
        longint pv, r, hi, lo;
        pv = longint'(p);
        if (s && p[2*w-1]) pv = pv - (longint'(1) << (2 * w));
        r  = (pv + (longint'(1) << (w - 2))) >>> (w - 1);
        hi = s ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        lo = s ? -(longint'(1) << (w - 1)) : 0;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return 64'(r) & ((64'd1 << w) - 64'd1);
    endfunction

    // ---------------- access helpers (no checking) ----------------
    function automatic logic get_ov(int w);
        return (w == 16) ? ov16 : ov8;
    endfunction

    function automatic logic get_ir(int w);
        return (w == 16) ? ir16 : ir8;
    endfunction

    function automatic logic [63:0] get_p(int w);
        return (w == 16) ? 64'(p16) : 64'(p8);
    endfunction

`ifdef MUL_Q15_OUT_EN
    function automatic logic [63:0] get_q(int w);
        return (w == 16) ? 64'(q16) : 64'(q8);
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int w, logic v, logic [31:0] a, logic [31:0] b, logic s);
        if (w == 16) begin
            iv16 = v; a16 = a[15:0]; b16 = b[15:0]; sg16 = s;
        end else begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0]; sg8 = s;
        end
    endtask

    task automatic set_or(int w, logic v);
        if (w == 16) or16 = v;
        else or8 = v;
    endtask

    // Presents operands, waits (bounded) for in_ready, then lets the handshake edge pass.
    task automatic send(int w, logic [31:0] a, logic [31:0] b, logic s);
        int n;
        set_in(w, 1'b1, a, b, s);
        n = 0;
        while (!get_ir(w) && n < 50) begin
            tick();
            n++;
        end
        tick();
        set_in(w, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_valid(int w, output int lat);
        lat = 0;
        while (!get_ov(w) && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_in(16, 1'b0, 32'd0, 32'd0, 1'b0);
        set_in(8, 1'b0, 32'd0, 32'd0, 1'b0);
        set_or(16, 1'b1);
        set_or(8, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? 16 : 8;
            checks++;
            if (get_ir(w) !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready w=%0d: got %b required 1", w, get_ir(w));
            end
            checks++;
            if (get_ov(w) !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid w=%0d: got %b required 0", w, get_ov(w));
            end
            checks++;
            if (get_p(w) !== 64'd0) begin
                errors++;
                $display("FAIL reset_out_p w=%0d: got %h required 0", w, get_p(w));
            end
`ifdef MUL_Q15_OUT_EN
            checks++;
            if (get_q(w) !== 64'd0) begin
                errors++;
                $display("FAIL reset_out_q w=%0d: got %h required 0", w, get_q(w));
            end
`endif
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed_products();
        logic [31:0] a, b, ep, eq;
        logic        s;
        int          lat;
        set_or(16, 1'b1);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin a = 32'hFFFF; b = 32'hFFFF; s = 1'b0; ep = 32'hFFFE0001; eq = 32'hFFFF; end
                1: begin a = 32'h8000; b = 32'h8000; s = 1'b1; ep = 32'h40000000; eq = 32'h7FFF; end
                2: begin a = 32'hFFFD; b = 32'h0007; s = 1'b1; ep = 32'hFFFFFFEB; eq = 32'h0000; end
                default: begin a = 32'h0005; b = 32'hFFFE; s = 1'b1; ep = 32'hFFFFFFF6; eq = 32'h0000; end
            endcase
            send(16, a, b, s);
            wait_valid(16, lat);
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL latency case%0d: got %0d cycles required 16", i, lat);
            end
            checks++;
            if (p16 !== ep) begin
                errors++;
                $display("FAIL product case%0d: got %h required %h", i, p16, ep);
            end
`ifdef MUL_Q15_OUT_EN
            checks++;
            if (32'(q16) !== eq) begin
                errors++;
                $display("FAIL q_result case%0d: got %h required %h", i, q16, eq);
            end
`endif
            tick();
            checks++;
            if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
                errors++;
                $display("FAIL return_to_idle case%0d: got valid=%b ready=%b required valid=0 ready=1",
                         i, ov16, ir16);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcap, ep;
        int          lat;
        set_or(16, 1'b0);
        send(16, 32'h1234, 32'h00FF, 1'b0);
        wait_valid(16, lat);
        pcap = p16;
        ep   = 32'(ref_p(16, 32'h1234, 32'h00FF, 1'b0));
        checks++;
        if (pcap !== ep) begin
            errors++;
            $display("FAIL bp_product: got %h required %h", pcap, ep);
        end
        for (int k = 0; k < 5; k++) begin
            set_in(16, (k % 2) == 0, $urandom, $urandom, 1'b1);
            tick();
            checks++;
            if (ov16 !== 1'b1 || ir16 !== 1'b0 || p16 !== ep) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got valid=%b ready=%b p=%h required valid=1 ready=0 p=%h",
                         k, ov16, ir16, p16, ep);
            end
        end
        set_in(16, 1'b0, 32'd0, 32'd0, 1'b0);
        set_or(16, 1'b1);
        tick();
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b required valid=0 ready=1", ov16, ir16);
        end
        send(16, 32'h0009, 32'h000B, 1'b0);
        wait_valid(16, lat);
        checks++;
        if (p16 !== 32'd99) begin
            errors++;
            $display("FAIL bp_next_product: got %h required %h", p16, 32'd99);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        set_or(16, 1'b1);
        send(16, 32'hABCD, 32'h1234, 1'b1);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_reset: got valid=%b ready=%b required valid=0 ready=1", ov16, ir16);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL abort_after_release: got valid=%b ready=%b required valid=0 ready=1", ov16, ir16);
        end
        send(16, 32'd3, 32'd4, 1'b0);
        wait_valid(16, lat);
        checks++;
        if (lat !== 16 || p16 !== 32'd12) begin
            errors++;
            $display("FAIL abort_then_3x4: got lat=%0d p=%h required lat=16 p=%h", lat, p16, 32'd12);
        end
        tick();
    endtask

    task automatic test_random_sweep(int w, int n);
        logic [63:0] exp_p[$];
        logic [63:0] exp_q[$];
        logic [31:0] a, b;
        logic        s, r, got;
        logic [63:0] pcap, qcap, e;
        int          sent, recvd, cyc;
        sent  = 0;
        recvd = 0;
        qcap  = '0;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 0) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            if (i == 1) begin a = 32'h0; end
            if (i == 2) begin a = 32'h1 << (w - 1); b = 32'h1 << (w - 1); s = 1'b1; end
            set_or(w, 1'b0);
            send(w, a, b, s);
            exp_p.push_back(ref_p(w, a, b, s));
            exp_q.push_back(ref_q(w, ref_p(w, a, b, s), s));
            sent++;
            got = 1'b0;
            cyc = 0;
            pcap = '0;
            while (!got && cyc < 200) begin
                r = 1'($urandom_range(0, 1));
                set_or(w, r);
                if (get_ov(w) && r) begin
                    got  = 1'b1;
                    pcap = get_p(w);
`ifdef MUL_Q15_OUT_EN
                    qcap = get_q(w);
`endif
                end
                tick();
                cyc++;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL sweep_timeout w=%0d item%0d: got no result required one", w, i);
            end else begin
                recvd++;
                e = exp_p.pop_front();
                checks++;
                if (pcap !== e) begin
                    errors++;
                    $display("FAIL sweep_product w=%0d item%0d a=%h b=%h s=%b: got %h required %h",
                             w, i, a, b, s, pcap, e);
                end
                e = exp_q.pop_front();
`ifdef MUL_Q15_OUT_EN
                checks++;
                if (qcap !== e) begin
                    errors++;
                    $display("FAIL sweep_q w=%0d item%0d: got %h required %h", w, i, qcap, e);
                end
`endif
            end
            checks++;
            if (get_ov(w) !== 1'b0) begin
                errors++;
                $display("FAIL sweep_duplicate w=%0d item%0d: got valid=%b required 0", w, i, get_ov(w));
            end
        end
        checks++;
        if (recvd !== sent || exp_p.size() != 0) begin
            errors++;
            $display("FAIL sweep_count w=%0d: got %0d results required %0d", w, recvd, sent);
        end
        set_or(w, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed_products();
        test_backpressure();
        test_reset_mid_run();
        test_random_sweep(16, 60);
        test_random_sweep(8, 60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
